// File: rtl/uart_move_parser.sv
// Bridges the UART FIFOs and the tic-tac-toe core: buffers one position digit,
// echoes accepted keys and offers a move over valid/ready when it is committed.
module uart_move_parser #(
  parameter bit ECHO_EN    = 1'b1,
  parameter bit REQUIRE_CR = 1'b1,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx_empty,
  input  logic [7:0]       r_data,
  output logic             rd_uart,
  input  logic             tx_full,
  output logic [7:0]       w_data,
  output logic             wr_uart,
  output logic [3:0]       move_pos,
  output logic             move_valid,
  input  logic             move_ready,
  output logic             pending,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLASSIFY,
    S_ECHO,
    S_ISSUE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_char;
  logic [3:0]       r_pendPos;
  logic             r_pending;
  logic             r_commit;
  logic             r_live;
  logic [ERR_W-1:0] r_errCnt;

  logic w_isDigit;
  logic w_isCr;
  logic w_isBs;
  logic w_setDigit;
  logic w_clrPend;
  logic w_incErr;
  logic w_commit;

  assign w_isDigit = (r_char >= 8'h31) && (r_char <= 8'h39);
  assign w_isCr    = (r_char == 8'h0D);
  assign w_isBs    = (r_char == 8'h08);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // r_live keeps the pop strobe quiet while reset is held, so queued bytes survive it
  always_comb begin
    w_next     = r_state;
    rd_uart    = 1'b0;
    wr_uart    = 1'b0;
    w_data     = 8'h00;
    move_valid = 1'b0;
    move_pos   = 4'd0;
    w_setDigit = 1'b0;
    w_clrPend  = 1'b0;
    w_incErr   = 1'b0;
    w_commit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rx_empty && r_live) begin
          rd_uart = 1'b1;
          w_next  = S_CLASSIFY;
        end
      end
      S_CLASSIFY: begin
        w_next = S_IDLE;
        if (w_isDigit) begin
          w_setDigit = 1'b1;
          w_commit   = !REQUIRE_CR;
          if (ECHO_EN)          w_next = S_ECHO;
          else if (!REQUIRE_CR) w_next = S_ISSUE;
        end else if (w_isCr) begin
          if (r_pending) begin
            w_commit = 1'b1;
            w_next   = ECHO_EN ? S_ECHO : S_ISSUE;
          end else begin
            w_incErr = 1'b1;
          end
        end else if (w_isBs) begin
          if (r_pending) begin
            w_clrPend = 1'b1;
            if (ECHO_EN) w_next = S_ECHO;
          end
        end else begin
          w_incErr = 1'b1;
        end
      end
      S_ECHO: begin
        if (!tx_full) begin
          wr_uart = 1'b1;
          w_data  = r_char;
          w_next  = r_commit ? S_ISSUE : S_IDLE;
        end
      end
      S_ISSUE: begin
        move_valid = 1'b1;
        move_pos   = r_pendPos;
        if (move_ready) begin
          w_clrPend = 1'b1;
          w_next    = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_live    <= 1'b0;
      r_char    <= 8'h00;
      r_pendPos <= 4'd0;
      r_pending <= 1'b0;
      r_commit  <= 1'b0;
      r_errCnt  <= '0;
    end else begin
      r_live <= 1'b1;
      if (rd_uart) r_char <= r_data;
      if (w_setDigit) begin
        r_pendPos <= r_char[3:0];
        r_pending <= 1'b1;
      end
      if (w_clrPend) r_pending <= 1'b0;
      if (r_state == S_CLASSIFY) r_commit <= w_commit;
      if (w_incErr && (r_errCnt != '1)) r_errCnt <= r_errCnt + 1'b1;
    end
  end

  assign pending = r_pending;
  assign err_cnt = r_errCnt;

endmodule

// File: tb/tb_uart_move_parser.sv
// Scoreboard bench: instance A echoes and waits for CR, instance B commits
// digits immediately with no echo and a 2-bit error counter.
module tb_uart_move_parser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstnA = 1'b1, rxEmptyA = 1'b1, txFullA = 1'b0, readyA = 1'b1;
  logic [7:0] rDataA = 8'h00;
  logic       rdA, wrA, mvA, pendA;
  logic [7:0] wDataA, errA;
  logic [3:0] posA;

  logic       rstnB = 1'b1, rxEmptyB = 1'b1, txFullB = 1'b0, readyB = 1'b1;
  logic [7:0] rDataB = 8'h00;
  logic       rdB, wrB, mvB, pendB;
  logic [7:0] wDataB;
  logic [1:0] errB;
  logic [3:0] posB;

  uart_move_parser #(.ECHO_EN(1'b1), .REQUIRE_CR(1'b1), .ERR_W(8)) dutA (
    .clk(clk), .reset_n(rstnA), .rx_empty(rxEmptyA), .r_data(rDataA), .rd_uart(rdA),
    .tx_full(txFullA), .w_data(wDataA), .wr_uart(wrA), .move_pos(posA),
    .move_valid(mvA), .move_ready(readyA), .pending(pendA), .err_cnt(errA)
  );

  uart_move_parser #(.ECHO_EN(1'b0), .REQUIRE_CR(1'b0), .ERR_W(2)) dutB (
    .clk(clk), .reset_n(rstnB), .rx_empty(rxEmptyB), .r_data(rDataB), .rd_uart(rdB),
    .tx_full(txFullB), .w_data(wDataB), .wr_uart(wrB), .move_pos(posB),
    .move_valid(mvB), .move_ready(readyB), .pending(pendB), .err_cnt(errB)
  );

  logic [7:0] rxQA[$], rxQB[$], expEchoA[$];
  logic [3:0] expMoveA[$], expMoveB[$];
  logic [7:0] expByte;
  logic [3:0] expPos;
  int  nChecks = 0, nFails = 0;
  int  cntRdA = 0, cntWrA = 0, cntMvA = 0, cntRdB = 0, cntMvB = 0;
  bit  popA = 0, popB = 0, prevRdA = 0, prevRdB = 0;

  task automatic updRx;
    rxEmptyA = (rxQA.size() == 0);
    rDataA   = (rxQA.size() == 0) ? 8'h00 : rxQA[0];
    rxEmptyB = (rxQB.size() == 0);
    rDataB   = (rxQB.size() == 0) ? 8'h00 : rxQB[0];
  endtask

  task automatic pushA(input logic [7:0] b);
    rxQA.push_back(b);
    updRx();
  endtask

  task automatic pushB(input logic [7:0] b);
    rxQB.push_back(b);
    updRx();
  endtask

  // Receive FIFO model: a pop seen during a cycle takes effect just after its closing edge
  always @(posedge clk) begin
    #1;
    if (popA && rxQA.size() > 0) void'(rxQA.pop_front());
    if (popB && rxQB.size() > 0) void'(rxQB.pop_front());
    popA = 0;
    popB = 0;
    updRx();
  end

  // Output monitor and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (rdA) begin
      popA = 1; cntRdA++; nChecks++;
      if (prevRdA) begin nFails++; $display("[TB] FAIL rdA_single_pulse: rd_uart high 2 cycles, required 1"); end
    end
    prevRdA = rdA;
    if (wrA) begin
      cntWrA++; nChecks++;
      if (txFullA) begin nFails++; $display("[TB] FAIL wrA_while_full: wr_uart=1 with tx_full=1, required 0"); end
      if (expEchoA.size() == 0) begin
        nFails++; $display("[TB] FAIL echoA_unexpected: got %h, required no write", wDataA);
      end else begin
        expByte = expEchoA.pop_front();
        if (wDataA !== expByte) begin nFails++; $display("[TB] FAIL echoA_data: got %h, required %h", wDataA, expByte); end
      end
    end
    if (mvA) begin
      nChecks++;
      if (posA < 4'd1 || posA > 4'd9) begin nFails++; $display("[TB] FAIL posA_range: got %0d, required 1..9", posA); end
      if (readyA) begin
        cntMvA++; nChecks++;
        if (expMoveA.size() == 0) begin
          nFails++; $display("[TB] FAIL moveA_unexpected: got pos %0d, required no move", posA);
        end else begin
          expPos = expMoveA.pop_front();
          if (posA !== expPos) begin nFails++; $display("[TB] FAIL moveA_pos: got %0d, required %0d", posA, expPos); end
        end
      end
    end
    if (rdB) begin
      popB = 1; cntRdB++; nChecks++;
      if (prevRdB) begin nFails++; $display("[TB] FAIL rdB_single_pulse: rd_uart high 2 cycles, required 1"); end
    end
    prevRdB = rdB;
    if (wrB) begin
      nChecks++; nFails++;
      $display("[TB] FAIL wrB_no_echo: wr_uart=1 data %h, required 0", wDataB);
    end
    if (mvB) begin
      nChecks++;
      if (posB < 4'd1 || posB > 4'd9) begin nFails++; $display("[TB] FAIL posB_range: got %0d, required 1..9", posB); end
      if (readyB) begin
        cntMvB++; nChecks++;
        if (expMoveB.size() == 0) begin
          nFails++; $display("[TB] FAIL moveB_unexpected: got pos %0d, required no move", posB);
        end else begin
          expPos = expMoveB.pop_front();
          if (posB !== expPos) begin nFails++; $display("[TB] FAIL moveB_pos: got %0d, required %0d", posB, expPos); end
        end
      end
    end
  end

  task automatic doResetA;
    rstnA = 1'b0; txFullA = 1'b0; readyA = 1'b1;
    rxQA.delete(); expEchoA.delete(); expMoveA.delete(); updRx();
    repeat (2) @(posedge clk);
    #2;
    cntRdA = 0; cntWrA = 0; cntMvA = 0; prevRdA = 0; popA = 0;
    rstnA = 1'b1;
  endtask

  task automatic doResetB;
    rstnB = 1'b0; readyB = 1'b1;
    rxQB.delete(); expMoveB.delete(); updRx();
    repeat (2) @(posedge clk);
    #2;
    cntRdB = 0; cntMvB = 0; prevRdB = 0; popB = 0;
    rstnB = 1'b1;
  endtask

  task automatic waitDrainA(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (rxQA.size() == 0 && expEchoA.size() == 0 && expMoveA.size() == 0) begin ok = 1; break; end
    end
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic waitDrainB(output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (rxQB.size() == 0 && expMoveB.size() == 0) begin ok = 1; break; end
    end
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rstnA = 1'b0; rstnB = 1'b0;
    pushA(8'h35); pushB(8'h36);
    @(negedge clk);
    nChecks += 9;
    if (rdA !== 1'b0)     begin nFails++; $display("[TB] FAIL reset_rd: got %b, required 0", rdA); end
    if (wrA !== 1'b0)     begin nFails++; $display("[TB] FAIL reset_wr: got %b, required 0", wrA); end
    if (wDataA !== 8'h00) begin nFails++; $display("[TB] FAIL reset_wdata: got %h, required 00", wDataA); end
    if (mvA !== 1'b0)     begin nFails++; $display("[TB] FAIL reset_valid: got %b, required 0", mvA); end
    if (posA !== 4'd0)    begin nFails++; $display("[TB] FAIL reset_pos: got %0d, required 0", posA); end
    if (pendA !== 1'b0)   begin nFails++; $display("[TB] FAIL reset_pending: got %b, required 0", pendA); end
    if (errA !== 8'd0)    begin nFails++; $display("[TB] FAIL reset_err: got %0d, required 0", errA); end
    if (rdB !== 1'b0)     begin nFails++; $display("[TB] FAIL resetB_rd: got %b, required 0", rdB); end
    if (rxQA.size() != 1) begin nFails++; $display("[TB] FAIL reset_fifo_kept: got %0d bytes, required 1", rxQA.size()); end
    doResetA();
    doResetB();
  endtask

  task automatic test_basic;
    bit ok;
    doResetA();
    pushA(8'h35); pushA(8'h0D);
    expEchoA.push_back(8'h35); expEchoA.push_back(8'h0D); expMoveA.push_back(4'd5);
    waitDrainA(ok);
    nChecks += 5;
    if (ok !== 1'b1)   begin nFails++; $display("[TB] FAIL basic_timeout: drained %b, required 1", ok); end
    if (cntRdA != 2)   begin nFails++; $display("[TB] FAIL basic_rd_count: got %0d, required 2", cntRdA); end
    if (cntWrA != 2)   begin nFails++; $display("[TB] FAIL basic_wr_count: got %0d, required 2", cntWrA); end
    if (cntMvA != 1)   begin nFails++; $display("[TB] FAIL basic_moves: got %0d, required 1", cntMvA); end
    if (pendA !== 1'b0) begin nFails++; $display("[TB] FAIL basic_pending: got %b, required 0", pendA); end
  endtask

  task automatic test_overwrite;
    bit ok;
    doResetA();
    pushA(8'h33); pushA(8'h37); pushA(8'h0D);
    expEchoA.push_back(8'h33); expEchoA.push_back(8'h37); expEchoA.push_back(8'h0D);
    expMoveA.push_back(4'd7);
    waitDrainA(ok);
    nChecks += 4;
    if (ok !== 1'b1)   begin nFails++; $display("[TB] FAIL overwrite_timeout: drained %b, required 1", ok); end
    if (cntMvA != 1)   begin nFails++; $display("[TB] FAIL overwrite_moves: got %0d, required 1", cntMvA); end
    if (cntWrA != 3)   begin nFails++; $display("[TB] FAIL overwrite_wr_count: got %0d, required 3", cntWrA); end
    if (pendA !== 1'b0) begin nFails++; $display("[TB] FAIL overwrite_pending: got %b, required 0", pendA); end
  endtask

  task automatic test_errors;
    bit ok;
    doResetA();
    pushA(8'h41); pushA(8'h30); pushA(8'h0D);
    waitDrainA(ok);
    nChecks += 5;
    if (ok !== 1'b1) begin nFails++; $display("[TB] FAIL errors_timeout: drained %b, required 1", ok); end
    if (errA !== 8'd3) begin nFails++; $display("[TB] FAIL errors_count: got %0d, required 3", errA); end
    if (cntWrA != 0) begin nFails++; $display("[TB] FAIL errors_wr_count: got %0d, required 0", cntWrA); end
    if (cntMvA != 0) begin nFails++; $display("[TB] FAIL errors_moves: got %0d, required 0", cntMvA); end
    if (cntRdA != 3) begin nFails++; $display("[TB] FAIL errors_rd_count: got %0d, required 3", cntRdA); end
  endtask

  task automatic test_backspace;
    bit ok;
    doResetA();
    pushA(8'h34); expEchoA.push_back(8'h34);
    waitDrainA(ok);
    nChecks++;
    if (pendA !== 1'b1) begin nFails++; $display("[TB] FAIL bs_pending_set: got %b, required 1", pendA); end
    pushA(8'h08); pushA(8'h0D); expEchoA.push_back(8'h08);
    waitDrainA(ok);
    nChecks += 5;
    if (ok !== 1'b1)    begin nFails++; $display("[TB] FAIL bs_timeout: drained %b, required 1", ok); end
    if (pendA !== 1'b0) begin nFails++; $display("[TB] FAIL bs_pending_clr: got %b, required 0", pendA); end
    if (errA !== 8'd1)  begin nFails++; $display("[TB] FAIL bs_err: got %0d, required 1", errA); end
    if (cntMvA != 0)    begin nFails++; $display("[TB] FAIL bs_moves: got %0d, required 0", cntMvA); end
    if (cntWrA != 2)    begin nFails++; $display("[TB] FAIL bs_wr_count: got %0d, required 2", cntWrA); end
  endtask

  task automatic test_stall;
    bit ok, seen;
    int vCycles, rdSnap;
    doResetA();
    txFullA = 1'b1; readyA = 1'b0;
    pushA(8'h39); pushA(8'h0D); pushA(8'h31);
    expEchoA.push_back(8'h39); expEchoA.push_back(8'h0D); expEchoA.push_back(8'h31);
    expMoveA.push_back(4'd9);
    repeat (10) @(posedge clk);
    #2;
    nChecks += 2;
    if (cntWrA != 0) begin nFails++; $display("[TB] FAIL stall_wr_early: got %0d writes, required 0", cntWrA); end
    if (cntRdA != 1) begin nFails++; $display("[TB] FAIL stall_rd_count: got %0d, required 1", cntRdA); end
    txFullA = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (mvA) begin seen = 1; break; end
    end
    nChecks++;
    if (!seen) begin nFails++; $display("[TB] FAIL stall_valid_timeout: move_valid 0, required 1"); end
    vCycles = (mvA && posA == 4'd9) ? 1 : 0;
    rdSnap  = cntRdA;
    for (int i = 2; i <= 6; i++) begin
      @(posedge clk); #2;
      if (i == 6) readyA = 1'b1;
      @(negedge clk);
      if (mvA && posA == 4'd9) vCycles++;
    end
    @(negedge clk);
    nChecks += 3;
    if (vCycles != 6)    begin nFails++; $display("[TB] FAIL stall_hold: got %0d stable cycles, required 6", vCycles); end
    if (cntRdA != rdSnap) begin nFails++; $display("[TB] FAIL stall_rd_in_issue: got %0d pops, required %0d", cntRdA, rdSnap); end
    if (mvA !== 1'b0)    begin nFails++; $display("[TB] FAIL stall_valid_drop: got %b, required 0", mvA); end
    waitDrainA(ok);
    nChecks += 3;
    if (ok !== 1'b1)    begin nFails++; $display("[TB] FAIL stall_timeout: drained %b, required 1", ok); end
    if (cntMvA != 1)    begin nFails++; $display("[TB] FAIL stall_moves: got %0d, required 1", cntMvA); end
    if (pendA !== 1'b1) begin nFails++; $display("[TB] FAIL stall_pending_next: got %b, required 1", pendA); end
  endtask

  task automatic test_immediate_reset;
    bit ok, seen;
    int kRd, kMv;
    doResetB();
    readyB = 1'b0;
    pushB(8'h32);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mvB) begin seen = 1; break; end
    end
    nChecks += 3;
    if (!seen)          begin nFails++; $display("[TB] FAIL imm_valid_timeout: move_valid 0, required 1"); end
    if (posB !== 4'd2)  begin nFails++; $display("[TB] FAIL imm_pos: got %0d, required 2", posB); end
    if (pendB !== 1'b1) begin nFails++; $display("[TB] FAIL imm_pending: got %b, required 1", pendB); end
    #2 rstnB = 1'b0;
    #1;
    nChecks += 2;
    if (mvB !== 1'b0)   begin nFails++; $display("[TB] FAIL imm_async_valid: got %b, required 0", mvB); end
    if (pendB !== 1'b0) begin nFails++; $display("[TB] FAIL imm_async_pending: got %b, required 0", pendB); end
    doResetB();
    pushB(8'h36); expMoveB.push_back(4'd6);
    kRd = -1; kMv = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rdB && kRd < 0) kRd = k;
      if (mvB) begin kMv = k; break; end
    end
    nChecks++;
    if (kMv - kRd != 2 || kRd < 0) begin nFails++; $display("[TB] FAIL imm_latency: got rd@%0d valid@%0d, required gap 2", kRd, kMv); end
    waitDrainB(ok);
    nChecks += 3;
    if (ok !== 1'b1)    begin nFails++; $display("[TB] FAIL imm_timeout: drained %b, required 1", ok); end
    if (cntMvB != 1)    begin nFails++; $display("[TB] FAIL imm_moves: got %0d, required 1", cntMvB); end
    if (pendB !== 1'b0) begin nFails++; $display("[TB] FAIL imm_pending_end: got %b, required 0", pendB); end
  endtask

  task automatic test_saturate;
    bit ok;
    doResetB();
    pushB(8'h41); pushB(8'h30); pushB(8'h0A); pushB(8'h0D); pushB(8'h5A);
    waitDrainB(ok);
    nChecks += 3;
    if (ok !== 1'b1)   begin nFails++; $display("[TB] FAIL sat_timeout: drained %b, required 1", ok); end
    if (errB !== 2'b11) begin nFails++; $display("[TB] FAIL sat_err: got %0d, required 3", errB); end
    if (cntMvB != 0)   begin nFails++; $display("[TB] FAIL sat_moves: got %0d, required 0", cntMvB); end
  endtask

  initial begin
    updRx();
    #1;
    test_reset();
    test_basic();
    test_overwrite();
    test_errors();
    test_backspace();
    test_stall();
    test_immediate_reset();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
